// File: rtl/ifu_pkg.sv
// Shared types and opcode constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {RUN, STALL_JALR} ifu_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } iq_entry_t;

  function automatic logic is_jalr(input logic [31:0] inst);
    return inst[6:0] == OPC_JALR;
  endfunction

  function automatic logic is_cti(input logic [31:0] inst);
    return (inst[6:0] == OPC_JALR) || (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: icache, branch predictor, commit redirect and decode handshake.
interface ifu_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_hit;
  logic [31:0] icache_inst;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        jalr_done;
  logic [31:0] jalr_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        iq_valid;
  logic        iq_ready;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_taken;
  logic [31:0] iq_pred_target;

  modport master (
    output icache_req, icache_addr, bp_pc,
    output iq_valid, iq_inst, iq_pc, iq_pred_taken, iq_pred_target,
    input  icache_hit, icache_inst, bp_taken, bp_target,
    input  jalr_done, jalr_target, flush, flush_pc, iq_ready
  );

  modport slave (
    input  icache_req, icache_addr, bp_pc,
    input  iq_valid, iq_inst, iq_pc, iq_pred_taken, iq_pred_target,
    output icache_hit, icache_inst, bp_taken, bp_target,
    output jalr_done, jalr_target, flush, flush_pc, iq_ready
  );
endinterface

// File: rtl/ifu_queue.sv
// Circular instruction queue: single push, single pop, synchronous clear.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     push,
  input  iq_entry_t                push_data,
  input  logic                     pop,
  output iq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int PTR_W = $clog2(DEPTH);

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W:0]   count_q;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (en) begin
      if (clear) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count_q  <= '0;
      end else begin
        if (push) tail_ptr <= tail_ptr + PTR_W'(1);
        if (pop)  head_ptr <= head_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (PTR_W+1)'(1);
          2'b01:   count_q <= count_q - (PTR_W+1)'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (en && push && !clear) mem[tail_ptr] <= push_data;
  end

  assign head  = mem[head_ptr];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC/FSM, icache and predictor glue feeding the instruction queue.
// Optional performance counters are built when IFU_PERF_EN is defined.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
`ifdef IFU_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  ifu_if.master       bus
);
  localparam int PTR_W = $clog2(IQ_DEPTH);

  ifu_state_e     state;
  logic [31:0]    pc;
  logic           active;
  logic           push;
  logic           pop;
  logic           q_full;
  logic [PTR_W:0] q_count;
  iq_entry_t      push_entry;
  iq_entry_t      head_entry;

  assign active = rdy_in && !rst_in;

  assign bus.icache_req  = active && (state == RUN) && !q_full;
  assign bus.icache_addr = pc;
  assign bus.bp_pc       = pc;
  assign bus.iq_valid    = active && (q_count != '0);

  // Flush wins over both queue operations; a hit in the flush cycle is dropped.
  assign push = bus.icache_req && bus.icache_hit && !bus.flush;
  assign pop  = bus.iq_valid && bus.iq_ready && !bus.flush;

  assign push_entry.inst        = bus.icache_inst;
  assign push_entry.pc          = pc;
  assign push_entry.pred_taken  = bus.bp_taken;
  assign push_entry.pred_target = bus.bp_taken ? bus.bp_target : 32'h0;

  ifu_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clear     (bus.flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (q_count),
    .full      (q_full)
  );

  assign bus.iq_inst        = head_entry.inst;
  assign bus.iq_pc          = head_entry.pc;
  assign bus.iq_pred_taken  = head_entry.pred_taken;
  assign bus.iq_pred_target = head_entry.pred_target;

  // PC and fetch FSM; a JALR parks the PC until the resolved target arrives.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (rdy_in) begin
      if (bus.flush) begin
        pc    <= bus.flush_pc;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (push) begin
              if (is_jalr(bus.icache_inst)) state <= STALL_JALR;
              else pc <= bus.bp_taken ? bus.bp_target : pc + 32'd4;
            end
          end
          STALL_JALR: begin
            if (bus.jalr_done) begin
              pc    <= bus.jalr_target;
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else if (rdy_in) begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if ((state == STALL_JALR) || q_full) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
